// File: rtl/psum_requant.sv
// psum_requant: accumulates a programmed number of psum beats, requantizes
// (shift + clamp) to 1..8 bits and queues results for the activation buffer.
module psum_requant #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cfg_len,
    input  logic [4:0]  cfg_shift,
    input  logic [3:0]  cfg_out_width,
    input  logic        cfg_signed,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_psum,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_sat,
    output logic        busy
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef struct packed {
        logic       sat;
        logic [7:0] data;
    } res_t;

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t      state, state_nx;
    logic [15:0] cnt, len_q;
    logic [4:0]  shift_q;
    logic [3:0]  w_q;
    logic        sgn_q;
    logic [31:0] acc;

    logic [15:0] cfg_len_eff, len_eff;
    logic [3:0]  cfg_w_eff, w;
    logic [4:0]  sh;
    logic        sg;
    logic [31:0] sum;
    logic        beat, final_beat;

    logic [31:0]        s, hi_u;
    logic signed [31:0] hi_s, lo_s;
    res_t               res;

    res_t            mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;
    logic            push, pop;

    assign beat = in_valid && in_ready;

    // Normalize config and pick live config on the first beat, latched config afterwards
    always_comb begin
        cfg_len_eff = (cfg_len == 16'd0) ? 16'd1 : cfg_len;
        cfg_w_eff   = (cfg_out_width == 4'd0 || cfg_out_width > 4'd8) ? 4'd8 : cfg_out_width;
        if (state == IDLE) begin
            len_eff = cfg_len_eff;
            sh      = cfg_shift;
            w       = cfg_w_eff;
            sg      = cfg_signed;
            sum     = in_psum;
        end else begin
            len_eff = len_q;
            sh      = shift_q;
            w       = w_q;
            sg      = sgn_q;
            sum     = acc + in_psum;
        end
        final_beat = beat && (cnt + 16'd1 == len_eff);
    end

    // Next-state: stay in ACCUM until the beat that completes the programmed length
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (beat && !final_beat) state_nx = ACCUM;
            ACCUM:   if (final_beat) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Accumulator, beat counter and per-result config latch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            acc     <= '0;
            len_q   <= 16'd1;
            shift_q <= '0;
            w_q     <= 4'd8;
            sgn_q   <= 1'b0;
        end else if (beat) begin
            acc <= sum;
            cnt <= final_beat ? 16'd0 : cnt + 16'd1;
            if (state == IDLE) begin
                len_q   <= cfg_len_eff;
                shift_q <= cfg_shift;
                w_q     <= cfg_w_eff;
                sgn_q   <= cfg_signed;
            end
        end
    end

    // Requantize the completed sum: shift, then clamp to the w-bit range
    always_comb begin
        s    = sg ? 32'($signed(sum) >>> sh) : (sum >> sh);
        hi_u = (32'd1 << w) - 32'd1;
        hi_s = $signed((32'd1 << (w - 4'd1)) - 32'd1);
        lo_s = ~hi_s;
        res  = '{sat: 1'b0, data: s[7:0]};
        if (sg) begin
            if ($signed(s) > hi_s)      res = '{sat: 1'b1, data: hi_s[7:0]};
            else if ($signed(s) < lo_s) res = '{sat: 1'b1, data: lo_s[7:0]};
        end else if (s > hi_u) begin
            res = '{sat: 1'b1, data: hi_u[7:0]};
        end
    end

    assign push      = final_beat;
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    // Gate on reset so upstream never sees a slot while the block is held
    assign in_ready  = !reset && (count != FULL);
    assign busy      = (cnt != 16'd0);
    assign out_data  = out_valid ? mem[rd_ptr].data : 8'd0;
    assign out_sat   = out_valid ? mem[rd_ptr].sat  : 1'b0;

    // FIFO storage; contents are don't-care while the slot is empty
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= res;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_psum_requant.sv
// Bench for psum_requant: directed vectors, a queue-based reference model
// checked every cycle, and literal expectations for each directed scenario.
module tb_psum_requant;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] cfg_len = 16'd1;
    logic [4:0]  cfg_shift = '0;
    logic [3:0]  cfg_out_width = 4'd8;
    logic        cfg_signed = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_psum = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_data;
    logic        out_sat;
    logic        busy;

    psum_requant #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .cfg_len(cfg_len), .cfg_shift(cfg_shift),
        .cfg_out_width(cfg_out_width), .cfg_signed(cfg_signed),
        .in_valid(in_valid), .in_ready(in_ready), .in_psum(in_psum),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sat(out_sat), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s got=%0h want=%0h", name, got, exp);
    endtask

    // Reference model: expected results in completion order, plus the
    // in-progress accumulation as plain integers.
    logic [8:0]  exp_q[$];
    logic [8:0]  log_q[$];
    int          m_cnt = 0, m_len = 1, m_sh = 0, m_w = 8;
    bit          m_sg = 1'b0;
    logic [31:0] m_acc = '0;

    function automatic logic [8:0] requant(input logic [31:0] a, input int sh, input int w, input bit sg);
        longint v, lo, hi;
        bit sat;
        if (sg) begin
            v  = longint'($signed(a));
            v  = v >>> sh;
            lo = -(longint'(1) << (w - 1));
            hi = (longint'(1) << (w - 1)) - 1;
        end else begin
            v  = longint'({32'd0, a});
            v  = v >> sh;
            lo = 0;
            hi = (longint'(1) << w) - 1;
        end
        sat = (v < lo) || (v > hi);
        if (v < lo) v = lo;
        if (v > hi) v = hi;
        return {sat, v[7:0]};
    endfunction

    task automatic model_beat(input logic [31:0] p);
        if (m_cnt == 0) begin
            m_len = (cfg_len == 0) ? 1 : int'(cfg_len);
            m_sh  = int'(cfg_shift);
            m_w   = (cfg_out_width == 0 || cfg_out_width > 8) ? 8 : int'(cfg_out_width);
            m_sg  = cfg_signed;
            m_acc = p;
        end else begin
            m_acc = m_acc + p;
        end
        m_cnt++;
        if (m_cnt == m_len) begin
            exp_q.push_back(requant(m_acc, m_sh, m_w, m_sg));
            m_cnt = 0;
        end
    endtask

    // Compare process: state after the last edge vs. model, then advance the
    // model with the handshakes that the next edge will take.
    always @(negedge clk) begin
        if (reset) begin
            chk("rst_in_ready", in_ready, 1'b0);
            chk("rst_out_valid", out_valid, 1'b0);
            chk("rst_out_data", out_data, 8'd0);
            chk("rst_out_sat", out_sat, 1'b0);
            chk("rst_busy", busy, 1'b0);
            exp_q.delete();
            m_cnt = 0;
        end else begin
            chk("in_ready", in_ready, exp_q.size() < DEPTH);
            chk("out_valid", out_valid, exp_q.size() != 0);
            chk("busy", busy, m_cnt != 0);
            if (out_valid && exp_q.size() > 0) begin
                chk("head", {out_sat, out_data}, exp_q[0]);
                if (out_ready) begin
                    log_q.push_back({out_sat, out_data});
                    void'(exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) model_beat(in_psum);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] p, input int maxc, output bit ok);
        in_valid = 1'b1;
        in_psum  = p;
        ok = 1'b0;
        for (int i = 0; i < maxc && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            step();
        end
        in_valid = 1'b0;
        in_psum  = '0;
    endtask

    task automatic sendx(input logic [31:0] p);
        bit ok;
        send(p, 40, ok);
        chk("accept", ok, 1'b1);
    endtask

    task automatic drain();
        int n = 0;
        while (out_valid && n < 40) begin
            step();
            n++;
        end
        if (out_valid) chk("drain_timeout", out_valid, 1'b0);
    endtask

    task automatic lit(input string name, input int idx, input logic [8:0] exp);
        if (log_q.size() > idx) chk(name, log_q[idx], exp);
        else chk({name, "_missing"}, log_q.size(), idx + 1);
    endtask

    task automatic set_cfg(input int len, input int sh, input int w, input bit sg);
        cfg_len       = 16'(len);
        cfg_shift     = 5'(sh);
        cfg_out_width = 4'(w);
        cfg_signed    = sg;
    endtask

    initial begin
        bit ok;
        repeat (3) step();
        reset = 1'b0;
        step();

        // 1: len=4 signed accumulation
        log_q.delete();
        set_cfg(4, 0, 8, 1'b1);
        sendx(32'd10);
        chk("t1_busy_after_first", busy, 1'b1);
        sendx(32'd20);
        sendx(-32'sd5);
        sendx(32'd3);
        chk("t1_latency", out_valid, 1'b1);
        chk("t1_busy_fall", busy, 1'b0);
        drain();
        lit("t1_result", 0, 9'h01C);
        chk("t1_count", log_q.size(), 1);

        // 2: len=1 signed clamp at width 8
        log_q.delete();
        set_cfg(1, 0, 8, 1'b1);
        sendx(32'd1000);
        sendx(-32'sd1000);
        sendx(-32'sd3);
        drain();
        lit("t2_pos_sat", 0, 9'h17F);
        lit("t2_neg_sat", 1, 9'h180);
        lit("t2_neg3", 2, 9'h0FD);

        // 3: unsigned, shift 2, width 4
        log_q.delete();
        set_cfg(1, 2, 4, 1'b0);
        sendx(32'h3C);
        sendx(32'h40);
        sendx(32'hFFFF_FFFF);
        drain();
        lit("t3_fit", 0, 9'h00F);
        lit("t3_sat", 1, 9'h10F);
        lit("t3_big", 2, 9'h10F);

        // 4: FIFO full backpressure, then drain in order
        log_q.delete();
        set_cfg(1, 0, 8, 1'b1);
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) sendx(32'(11 + i));
        chk("t4_full_in_ready", in_ready, 1'b0);
        send(32'd15, 3, ok);
        chk("t4_blocked", ok, 1'b0);
        out_ready = 1'b1;
        sendx(32'd15);
        sendx(32'd16);
        drain();
        for (int i = 0; i < 6; i++) lit("t4_order", i, 9'(11 + i));

        // 5: reset mid-accumulation discards the partial sum
        log_q.delete();
        set_cfg(4, 0, 8, 1'b1);
        sendx(32'd7);
        sendx(32'd9);
        chk("t5_busy_mid", busy, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        step();
        reset = 1'b0;
        chk("t5_busy_after_rst", busy, 1'b0);
        chk("t5_no_output", out_valid, 1'b0);
        for (int i = 0; i < 4; i++) sendx(32'd1);
        drain();
        lit("t5_result", 0, 9'h004);
        chk("t5_count", log_q.size(), 1);

        // 6: len=0 acts as 1; mid-accumulation len change is ignored
        log_q.delete();
        set_cfg(0, 0, 8, 1'b1);
        sendx(32'd5);
        sendx(32'd6);
        sendx(32'd7);
        cfg_len = 16'd3;
        sendx(32'd10);
        cfg_len = 16'd1;
        chk("t6_busy_len3", busy, 1'b1);
        sendx(32'd20);
        sendx(32'd30);
        drain();
        lit("t6_len0_a", 0, 9'h005);
        lit("t6_len0_b", 1, 9'h006);
        lit("t6_len0_c", 2, 9'h007);
        lit("t6_len3", 3, 9'h03C);
        chk("t6_count", log_q.size(), 4);

        step();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule
